// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the MAR/RAM write-port arbiter:
//   - arbiter state encoding
//   - default parameter values
//   - bus-select codes driven by the control unit (kept here so the control
//     unit and the arbiter agree on one set of constants)
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAR   = 3'd1,
    ST_WR    = 3'd2,
    ST_HOLD  = 3'd3,
    ST_YIELD = 3'd4
  } arb_state_t;

  // Bus source select codes used by the control unit.
  localparam logic [2:0] BUS_SEL_NONE = 3'd0;
  localparam logic [2:0] BUS_SEL_PC   = 3'd1;
  localparam logic [2:0] BUS_SEL_A    = 3'd2;
  localparam logic [2:0] BUS_SEL_B    = 3'd3;
  localparam logic [2:0] BUS_SEL_ALU  = 3'd4;
  localparam logic [2:0] BUS_SEL_RAM  = 3'd5;
  localparam logic [2:0] BUS_SEL_IR   = 3'd6;

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single MAR/RAM write port between the CPU control unit and an
// external program loader. The loader is granted only at an instruction
// boundary or while the CPU is halted; while it owns the port the CPU step
// sequencer is stalled. Bursts are capped at MAX_BURST writes, after which the
// port is handed back until the CPU leaves its boundary (one instruction runs).
//
// Ports:
//   clock, bReset            clock, synchronous active-low reset
//   cpu_mar_we, cpu_ram_we   CPU MAR-load / RAM-write requests
//   cpu_bus                  CPU bus value
//   cpu_boundary, cpu_hlt    CPU at step 0 / CPU halted
//   cpu_stall                freezes CPU step counter and its enables
//   ld_valid/ld_addr/ld_data loader request, address, data
//   ld_ready                 loader write accepted this cycle
//   mar_we, mar_d            MAR load enable and data
//   ram_we, ram_d            RAM write enable and data
//   ld_count                 total accepted loader writes (wraps at 256)
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clock,
  input  logic              bReset,
  input  logic              cpu_mar_we,
  input  logic              cpu_ram_we,
  input  logic [DATA_W-1:0] cpu_bus,
  input  logic              cpu_boundary,
  input  logic              cpu_hlt,
  output logic              cpu_stall,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              mar_we,
  output logic [DATA_W-1:0] mar_d,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_d,
  output logic [7:0]        ld_count
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);

  arb_state_t         r_state;
  arb_state_t         w_state_next;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [BURST_W-1:0] w_burst_next;
  logic [BURST_W-1:0] w_burst_inc;
  logic [7:0]         r_ld_count;
  logic [7:0]         w_ld_count_next;
  logic [DATA_W-1:0]  w_addr_ext;

  assign ld_count    = r_ld_count;
  assign w_burst_inc = r_burst_cnt + BURST_W'(1);
  assign w_addr_ext  = DATA_W'(ld_addr);

  always_ff @(posedge clock) begin
    if (!bReset) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
      r_ld_count  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_burst_cnt <= w_burst_next;
      r_ld_count  <= w_ld_count_next;
    end
  end

  always_comb begin
    // Default: CPU pass-through, state held.
    w_state_next    = r_state;
    w_burst_next    = r_burst_cnt;
    w_ld_count_next = r_ld_count;
    cpu_stall       = 1'b0;
    ld_ready        = 1'b0;
    mar_we          = cpu_mar_we;
    ram_we          = cpu_ram_we;
    mar_d           = cpu_bus;
    ram_d           = cpu_bus;

    case (r_state)
      ST_IDLE: begin
        w_burst_next = '0;
        if (ld_valid && (cpu_boundary || cpu_hlt)) begin
          w_state_next = ST_MAR;
        end
      end

      ST_MAR: begin
        cpu_stall    = 1'b1;
        mar_we       = 1'b1;
        ram_we       = 1'b0;
        mar_d        = w_addr_ext;
        ram_d        = ld_data;
        // A loader that drops valid here has broken protocol; park in HOLD.
        w_state_next = ld_valid ? ST_WR : ST_HOLD;
      end

      ST_WR: begin
        cpu_stall    = 1'b1;
        mar_we       = 1'b0;
        mar_d        = w_addr_ext;
        ram_d        = ld_data;
        ram_we       = ld_valid;
        ld_ready     = ld_valid;
        w_state_next = ST_HOLD;
        if (ld_valid) begin
          w_ld_count_next = r_ld_count + 8'd1;
          w_burst_next    = w_burst_inc;
          if (w_burst_inc == BURST_W'(MAX_BURST)) begin
            w_state_next = ST_YIELD;
          end
        end
      end

      ST_HOLD: begin
        cpu_stall = 1'b1;
        mar_we    = 1'b0;
        ram_we    = 1'b0;
        mar_d     = w_addr_ext;
        ram_d     = ld_data;
        if (ld_valid) begin
          w_state_next = ST_MAR;
        end else begin
          w_state_next = ST_IDLE;
          w_burst_next = '0;
        end
      end

      ST_YIELD: begin
        // Stay here while the CPU sits at a boundary so that a full
        // instruction executes before the loader can be regranted.
        w_burst_next = '0;
        if (!cpu_boundary || cpu_hlt) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_burst_next = '0;
      end
    endcase

    // Reset quiesces the port combinationally, aborting any transfer.
    if (!bReset) begin
      cpu_stall = 1'b0;
      ld_ready  = 1'b0;
      mar_we    = 1'b0;
      ram_we    = 1'b0;
      mar_d     = '0;
      ram_d     = '0;
    end
  end

endmodule
